hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It produces the PC and pipeline-register write enables, the flush controls and the PC redirect select. It does this from three inputs: load-use dependencies between ID and EX, jumps and branches resolved in EX, and data-memory wait states in MEM. It also keeps saturating stall and flush performance counters and a sticky memory-timeout error.

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// jump-type encodings, FSM states, control-bundle layout and parameter defaults.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int MEM_TIMEOUT_DEF = 255;

    localparam logic [1:0] NO_JUMP = 2'b00;
    localparam logic [1:0] JAL     = 2'b01;
    localparam logic [1:0] JAL_R   = 2'b10;
    localparam logic [1:0] BRANCH  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_WAIT_MEM = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic pc_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_FROZEN   = '0;
    localparam ctrl_t CTRL_RUN      = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                        ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                        if_id_flush: 1'b0, id_ex_flush: 1'b0, pc_sel: 1'b0};
    localparam ctrl_t CTRL_REDIRECT = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                        ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                        if_id_flush: 1'b1, id_ex_flush: 1'b1, pc_sel: 1'b1};
    localparam ctrl_t CTRL_BUBBLE   = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b1,
                                        ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                        if_id_flush: 1'b0, id_ex_flush: 1'b1, pc_sel: 1'b0};

    function automatic logic is_redirect(input logic [1:0] jump_t, input logic br_taken);
        return (jump_t == JAL) || (jump_t == JAL_R) || ((jump_t == BRANCH) && br_taken);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use bubbles, EX
// redirects, data-memory wait freezes, perf counters and a sticky timeout flag.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [1:0]       ex_jump_t,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic              redirect;
    logic              load_use;
    logic              mem_stall;
    state_e            state_q, state_d;
    ctrl_t             ctrl_c, ctrl_o;
    logic              stall_inc, flush_inc;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    assign redirect  = is_redirect(ex_jump_t, ex_br_taken);
    assign mem_stall = mem_req && !dmem_ready;
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        ctrl_c    = CTRL_FROZEN;
        state_d   = state_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (mem_stall) begin
            state_d   = ST_WAIT_MEM;
            stall_inc = 1'b1;
        end else if (redirect) begin
            ctrl_c    = CTRL_REDIRECT;
            state_d   = ST_RUN;
            flush_inc = 1'b1;
        end else if (load_use && (state_q != ST_BUBBLE)) begin
            ctrl_c    = CTRL_BUBBLE;
            state_d   = ST_BUBBLE;
            stall_inc = 1'b1;
        end else begin
            ctrl_c  = CTRL_RUN;
            state_d = ST_RUN;
        end
    end

    // Wait length counts the stalled cycle that enters WAIT_MEM as the first one.
    always_comb begin
        wait_cnt_d = '0;
        err_d      = err_q;
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;
            err_d      = err_q || (wait_cnt_q >= WAIT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign ctrl_o      = rst_n ? ctrl_c : CTRL_FROZEN;
    assign pc_we       = ctrl_o.pc_we;
    assign if_id_we    = ctrl_o.if_id_we;
    assign id_ex_we    = ctrl_o.id_ex_we;
    assign ex_mem_we   = ctrl_o.ex_mem_we;
    assign mem_wb_we   = ctrl_o.mem_wb_we;
    assign if_id_flush = ctrl_o.if_id_flush;
    assign id_ex_flush = ctrl_o.id_ex_flush;
    assign pc_sel      = ctrl_o.pc_sel;
    assign mem_err     = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a rule-level model.
module tb_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CW   = 4;
    localparam int TO   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // Expected control vectors {pc,if_id,id_ex,ex_mem,mem_wb we, if_id_fl, id_ex_fl, pc_sel}
    localparam logic [7:0] V_FRZ = 8'b00000_000;
    localparam logic [7:0] V_RUN = 8'b11111_000;
    localparam logic [7:0] V_RED = 8'b11111_111;
    localparam logic [7:0] V_BUB = 8'b00111_010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, dmem_ready;
    logic [1:0]    ex_jump_t;
    logic          pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic          if_id_flush, id_ex_flush, pc_sel, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int m_stall = 0;
    int m_flush = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;
    bit m_prev_bubble = 1'b0;

    hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_jump_t   (ex_jump_t),
        .ex_br_taken (ex_br_taken),
        .mem_req     (mem_req),
        .dmem_ready  (dmem_ready),
        .pc_we       (pc_we),
        .if_id_we    (if_id_we),
        .id_ex_we    (id_ex_we),
        .ex_mem_we   (ex_mem_we),
        .mem_wb_we   (mem_wb_we),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .pc_sel      (pc_sel),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctrl_vec();
        return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush, pc_sel};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    // Per-cycle comparison against the model, then advance the model by one cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ctrl", int'(ctrl_vec()), int'(V_FRZ));
            check("rst_stall_cnt", int'(stall_cnt), 0);
            check("rst_flush_cnt", int'(flush_cnt), 0);
            check("rst_mem_err", int'(mem_err), 0);
            m_stall = 0; m_flush = 0; m_wait = 0; m_err = 1'b0; m_prev_bubble = 1'b0;
        end else begin
            bit         ms, rd, lu;
            logic [7:0] exp_v;
            ms = mem_req && !dmem_ready;
            rd = (ex_jump_t == 2'b01) || (ex_jump_t == 2'b10) || (ex_jump_t == 2'b11 && ex_br_taken);
            lu = ex_mem_read && ex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            if (ms)                         exp_v = V_FRZ;
            else if (rd)                    exp_v = V_RED;
            else if (lu && !m_prev_bubble)  exp_v = V_BUB;
            else                            exp_v = V_RUN;
            check("ctrl", int'(ctrl_vec()), int'(exp_v));
            check("stall_cnt", int'(stall_cnt), m_stall);
            check("flush_cnt", int'(flush_cnt), m_flush);
            check("mem_err", int'(mem_err), int'(m_err));
            if (exp_v[7] == 1'b0) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (exp_v == V_RED)   m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            m_wait = ms ? m_wait + 1 : 0;
            if (m_wait >= TO) m_err = 1'b1;
            m_prev_bubble = (exp_v == V_BUB);
        end
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_jump_t = NO_JUMP; ex_br_taken = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic load_use_in();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        idle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        check("t0_reset_ctrl", int'(ctrl_vec()), int'(V_FRZ));
        check("t0_reset_stall", int'(stall_cnt), 0);
        check("t0_reset_err", int'(mem_err), 0);
        next_cycle();
        rst_n = 1'b1;

        // Load-use: exactly one bubble even with the dependency held
        load_use_in();
        sample();
        check("lu_bubble", int'(ctrl_vec()), int'(V_BUB));
        next_cycle();
        sample();
        check("lu_after", int'(ctrl_vec()), int'(V_RUN));
        check("lu_stall_cnt", int'(stall_cnt), 1);
        next_cycle(); idle();
        sample();
        check("lu_stall_hold", int'(stall_cnt), 1);

        // Load to x0 never stalls
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        sample();
        check("x0_ctrl", int'(ctrl_vec()), int'(V_RUN));
        next_cycle(); idle();
        sample();
        check("x0_stall_cnt", int'(stall_cnt), 0);

        // Taken branch beats a concurrent load-use
        do_reset();
        load_use_in();
        ex_jump_t = BRANCH; ex_br_taken = 1'b1;
        sample();
        check("br_ctrl", int'(ctrl_vec()), int'(V_RED));
        next_cycle(); idle();
        sample();
        check("br_ctrl_next", int'(ctrl_vec()), int'(V_RUN));
        check("br_flush_cnt", int'(flush_cnt), 1);
        check("br_stall_cnt", int'(stall_cnt), 0);

        // JAL_R held behind a 3-cycle memory wait
        do_reset();
        ex_jump_t = JAL_R; mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("jalr_frozen", int'(ctrl_vec()), int'(V_FRZ));
            next_cycle();
        end
        dmem_ready = 1'b1;
        sample();
        check("jalr_release", int'(ctrl_vec()), int'(V_RED));
        next_cycle(); idle();
        sample();
        check("jalr_stall_cnt", int'(stall_cnt), 3);
        check("jalr_flush_cnt", int'(flush_cnt), 1);
        check("jalr_no_err", int'(mem_err), 0);

        // Timeout after the 4th consecutive stalled cycle, sticky afterwards
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            check("to_err", int'(mem_err), (i >= 4) ? 1 : 0);
            next_cycle();
        end
        idle();
        sample();
        check("to_release_ctrl", int'(ctrl_vec()), int'(V_RUN));
        check("to_err_sticky", int'(mem_err), 1);

        // Reset in the middle of WAIT_MEM
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (5) next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rwait_ctrl", int'(ctrl_vec()), int'(V_FRZ));
        check("rwait_stall_cnt", int'(stall_cnt), 0);
        check("rwait_err", int'(mem_err), 0);
        next_cycle();
        idle();
        rst_n = 1'b1;
        sample();
        check("rwait_run", int'(ctrl_vec()), int'(V_RUN));

        // Reset in the middle of BUBBLE: a held dependency bubbles again afterwards
        do_reset();
        load_use_in();
        next_cycle();
        #2;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        sample();
        check("rbub_bubble", int'(ctrl_vec()), int'(V_BUB));

        // Saturation of the stall counter
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (20) next_cycle();
        idle();
        sample();
        check("sat_stall_cnt", int'(stall_cnt), CMAX);

        // Randomized traffic, checked every cycle by the compare process
        do_reset();
        begin
            int burst;
            burst = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                id_rs1      = 5'($urandom_range(0, 3));
                id_rs2      = 5'($urandom_range(0, 3));
                id_use_rs1  = 1'($urandom_range(0, 1));
                id_use_rs2  = 1'($urandom_range(0, 1));
                ex_rd       = 5'($urandom_range(0, 3));
                ex_mem_read = 1'($urandom_range(0, 1));
                ex_jump_t   = 2'($urandom_range(0, 3));
                ex_br_taken = 1'($urandom_range(0, 1));
                if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 7);
                if (burst > 0) begin
                    mem_req = 1'b1; dmem_ready = 1'b0; burst--;
                end else begin
                    mem_req    = ($urandom_range(0, 2) == 0);
                    dmem_ready = ($urandom_range(0, 3) != 0);
                end
                if ($urandom_range(0, 63) == 0) begin
                    rst_n = 1'b0;
                    burst = 0;
                    next_cycle();
                    rst_n = 1'b1;
                end else begin
                    next_cycle();
                end
            end
        end

        idle();
        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
